grid_clb_param: RTL and testbench
=================================

Name: grid_clb_param

Overview:
- Parametrised successor of the fixed CLB tile: N_BLE basic logic elements (BLEs). Each BLE is a K-input LUT, a flip-flop and an output-select bit.
- Each LUT input is driven by a configurable input crossbar.
- Configuration is loaded through a serial ccff chain with length checking. The tile stays output-silent until a correctly sized bitstream has been loaded.
- User flip-flops form a scan chain for test. Instantiated per CLB grid location, with ccff_head/ccff_tail daisy-chained across tiles.

Parameters:
- N_BLE, 4, number of BLEs (= clb_O width).
- K, 4, LUT input count.
- I_W, 10, number of tile routing inputs (clb_I width).
- SELW, derived = $clog2(I_W+N_BLE), crossbar select width per LUT input.
- CFG_PER_BLE, derived = K*SELW + 2**K + 1.
- CFG_BITS, derived = N_BLE*CFG_PER_BLE (132 at defaults).

Ports:
- clb_clk, in, 1: single clock for configuration shift and user logic.
- pReset, in, 1: synchronous, active-low reset.
- config_enable, in, 1: high = configuration shift mode.
- Test_en, in, 1: scan mode for user flip-flops.
- ccff_head, in, 1: serial configuration data in.
- clb_I, in, I_W: routing inputs.
- clb_sc_in, in, 1: scan in.
- clb_O, out, N_BLE: BLE outputs.
- clb_sc_out, out, 1: scan out = q[N_BLE-1].
- ccff_tail, out, 1: cfg[CFG_BITS-1].
- cfg_valid, out, 1: configuration accepted.
- cfg_err, out, 1: last load had the wrong length.

Behaviour:
- Reset: pReset=0 at a clb_clk edge clears cfg[], q[], shift count, cfg_valid and cfg_err. Consequently clb_O=0, ccff_tail=0 and clb_sc_out=0 from the next cycle. Reset overrides everything, including a load in progress.
- Config shift: each edge with config_enable=1 does cfg <= {cfg[CFG_BITS-2:0], ccff_head}.
  - cnt increments and saturates at CFG_BITS+1 (overflow marker).
  - cfg_valid and cfg_err are cleared on that edge.
  - Because bit 0 enters first and shifts toward the MSB, the first bit streamed lands in cfg[CFG_BITS-1].
- Load check: on the first edge with config_enable=0 after a shift period:
  - cnt==CFG_BITS: cfg_valid<=1, cfg_err<=0.
  - otherwise: cfg_valid<=0, cfg_err<=1.
  - Then cnt<=0 in both cases.
  - Re-asserting config_enable starts a fresh load from cnt=0.
- Config bit map, BLE i at offset i*CFG_PER_BLE (offsets relative to that base):
  - sel[k] = bits [k*SELW +: SELW];
  - LUT truth table = bits [K*SELW +: 2**K];
  - mode = bit K*SELW + 2**K.
- Crossbar: source index j < I_W selects clb_I[j]. I_W <= j < I_W+N_BLE selects q[j-I_W] (registered feedback only; no combinational loops). j >= I_W+N_BLE selects 0.
- LUT: lut_out[i] = truth[{in[K-1],...,in[0]}], where in[0] is the LSB of the index.
- Output: clb_O[i] = mode ? q[i] : lut_out[i].
  - Forced to 0 whenever cfg_valid=0 or config_enable=1.
  - This is the secure-silence requirement; it is combinational with respect to cfg_valid.
- Flip-flops, with priority config_enable > Test_en > normal:
  - config_enable=1: q holds.
  - Test_en=1: q[0]<=clb_sc_in, q[i]<=q[i-1] (shift regardless of cfg_valid).
  - Otherwise, if cfg_valid: q[i]<=lut_out[i].
  - Otherwise: q holds.
- Latency:
  - Combinational path clb_I -> clb_O: 0 cycles when mode=0.
  - Registered path when mode=1: 1 cycle.
  - cfg_valid rises 1 cycle after config_enable falls.

Decomposition:
- Package clb_param_pkg: functions for sel_width(I_W,N_BLE), cfg_per_ble(K,SELW), cfg_bits(...), plus bit-offset localparams for sel, truth and mode fields.
- Sub-module clb_ble: one BLE containing the crossbar mux, the LUT, the FF with scan/hold/load priority, and the output mux. It receives its cfg slice, the source bus, sc_in_local and gating enables.
- Top level contains: shift register, counter/check FSM (IDLE/SHIFT/CHECK implied by config_enable edge and cnt), and a generate loop over clb_ble.

Test Plan (defaults N_BLE=4, K=4, I_W=10, CFG_BITS=132):
- Reset: drive pReset=0 for 1 edge with random inputs -> clb_O=0, cfg_valid=0, cfg_err=0, ccff_tail=0, clb_sc_out=0.
- Exact load, mode=0: stream 132 bits programming BLE0 with sel[0]=0 and truth=16'hAAAA (buffer of in[0]). Deassert config_enable -> cfg_valid=1 after 1 cycle; toggling clb_I[0] drives clb_O[0] the same cycle.
- Short/long load: stream 131 bits, then in a separate load 133 bits -> cfg_err=1, cfg_valid=0, clb_O stays 0 in both cases. A following 132-bit load clears cfg_err.
- Registered feedback: BLE1 mode=1, sel[0]=11 (q[1]), truth=16'h5555 (inverter) -> clb_O[1] toggles every clb_clk (0,1,0,...). ccff_tail equals the bit shifted in 132 edges earlier.
- Scan: Test_en=1, shift pattern 1,0,1,1 on clb_sc_in -> clb_sc_out shows the first bit after 4 edges. Asserting config_enable mid-scan freezes q and forces clb_O=0.
- Reset mid-load: pReset=0 after 60 shift edges, then a fresh 132-bit load -> cfg_valid=1, no cfg_err, and the earlier partial bits are absent from cfg.

Source files
------------

// File: rtl/clb_param_pkg.sv
// Shared sizing helpers and types for the parametrised CLB tile.
package clb_param_pkg;

  // Default tile geometry
  localparam int DEF_N_BLE = 4;
  localparam int DEF_K     = 4;
  localparam int DEF_I_W   = 10;

  // Crossbar select width: enough to address every routing input plus every BLE feedback
  function automatic int sel_width(input int i_w, input int n_ble);
    return $clog2(i_w + n_ble);
  endfunction

  // Configuration bits owned by one BLE: K selects, the truth table, the mode bit
  function automatic int cfg_per_ble(input int k, input int selw);
    return k * selw + (1 << k) + 1;
  endfunction

  // Total length of the configuration chain
  function automatic int cfg_bits(input int n_ble, input int per_ble);
    return n_ble * per_ble;
  endfunction

  // Offset of select field idx inside a BLE slice
  function automatic int sel_off(input int idx, input int selw);
    return idx * selw;
  endfunction

  // Offset of the truth table inside a BLE slice
  function automatic int truth_off(input int k, input int selw);
    return k * selw;
  endfunction

  // Offset of the mode bit inside a BLE slice
  function automatic int mode_off(input int k, input int selw);
    return k * selw + (1 << k);
  endfunction

  // Loader state: idle, or in a shift period that is checked when config_enable drops
  typedef enum logic {
    LOAD_IDLE  = 1'b0,
    LOAD_SHIFT = 1'b1
  } load_state_e;

endpackage

// File: rtl/clb_ble.sv
// One basic logic element: input crossbar, K-input LUT, scan/load flip-flop, output select.
module clb_ble
  import clb_param_pkg::*;
#(
  parameter int K     = DEF_K,
  parameter int I_W   = DEF_I_W,
  parameter int N_BLE = DEF_N_BLE,
  localparam int SELW  = sel_width(I_W, N_BLE),
  localparam int CPB   = cfg_per_ble(K, SELW),
  localparam int SRC_W = I_W + N_BLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CPB-1:0]   cfg,
  input  logic [SRC_W-1:0] src,
  input  logic             sc_in_local,
  input  logic             hold_en,
  input  logic             scan_en,
  input  logic             load_en,
  input  logic             out_en,
  output logic             q,
  output logic             o
);

  localparam int TRUTH_OFF = truth_off(K, SELW);
  localparam int MODE_OFF  = mode_off(K, SELW);

  logic [SELW-1:0]   sel [K];
  logic [K-1:0]      lut_idx;
  logic [2**K-1:0]   truth;
  logic              lut_out;
  logic              mode;
  logic              q_d;
  logic              q_q;

  // Crossbar: each LUT input picks a source index; indices past the bus read as 0
  always_comb begin
    for (int k = 0; k < K; k++) begin
      sel[k]     = cfg[sel_off(k, SELW) +: SELW];
      lut_idx[k] = 1'b0;
      for (int j = 0; j < SRC_W; j++) begin
        if (sel[k] == SELW'(j)) begin
          lut_idx[k] = src[j];
        end
      end
    end
  end

  assign truth   = cfg[TRUTH_OFF +: 2**K];
  assign lut_out = truth[lut_idx];
  assign mode    = cfg[MODE_OFF];

  // Flip-flop next state: configuration holds, then scan shift, then LUT load when configured
  always_comb begin
    q_d = q_q;
    if (hold_en) begin
      q_d = q_q;
    end else if (scan_en) begin
      q_d = sc_in_local;
    end else if (load_en) begin
      q_d = lut_out;
    end
  end

  // User flip-flop with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

  // Output select, silenced unless the tile holds an accepted configuration
  always_comb begin
    o = 1'b0;
    if (out_en) begin
      o = mode ? q_q : lut_out;
    end
  end

endmodule

// File: rtl/grid_clb_param.sv
// Parametrised CLB tile: serial configuration chain with length check and N_BLE logic elements.
module grid_clb_param
  import clb_param_pkg::*;
#(
  parameter int N_BLE = DEF_N_BLE,
  parameter int K     = DEF_K,
  parameter int I_W   = DEF_I_W
) (
  input  logic             clb_clk,
  input  logic             pReset,
  input  logic             config_enable,
  input  logic             Test_en,
  input  logic             ccff_head,
  input  logic [I_W-1:0]   clb_I,
  input  logic             clb_sc_in,
  output logic [N_BLE-1:0] clb_O,
  output logic             clb_sc_out,
  output logic             ccff_tail,
  output logic             cfg_valid,
  output logic             cfg_err
);

  localparam int SELW        = sel_width(I_W, N_BLE);
  localparam int CFG_PER_BLE = cfg_per_ble(K, SELW);
  localparam int CFG_BITS    = cfg_bits(N_BLE, CFG_PER_BLE);
  localparam int CNT_W       = $clog2(CFG_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(CFG_BITS + 1);

  logic [CFG_BITS-1:0] cfg_d, cfg_q;
  logic [CNT_W-1:0]    cnt_d, cnt_q;
  logic                cfg_valid_d, cfg_valid_q;
  logic                cfg_err_d, cfg_err_q;
  load_state_e         state_d, state_q;

  logic [N_BLE-1:0]    q_vec;
  logic [N_BLE-1:0]    sc_chain;
  logic                out_en;

  // Loader: shift while enabled, then judge the length on the first idle edge
  always_comb begin
    cfg_d       = cfg_q;
    cnt_d       = cnt_q;
    cfg_valid_d = cfg_valid_q;
    cfg_err_d   = cfg_err_q;
    state_d     = state_q;
    if (config_enable) begin
      cfg_d       = {cfg_q[CFG_BITS-2:0], ccff_head};
      cfg_valid_d = 1'b0;
      cfg_err_d   = 1'b0;
      state_d     = LOAD_SHIFT;
      if (cnt_q != CNT_OVF) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (state_q == LOAD_SHIFT) begin
      cfg_valid_d = (cnt_q == CNT_FULL);
      cfg_err_d   = (cnt_q != CNT_FULL);
      cnt_d       = '0;
      state_d     = LOAD_IDLE;
    end
  end

  // Loader registers with synchronous active-low reset overriding any load in progress
  always_ff @(posedge clb_clk) begin
    if (!pReset) begin
      cfg_q       <= '0;
      cnt_q       <= '0;
      cfg_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      state_q     <= LOAD_IDLE;
    end else begin
      cfg_q       <= cfg_d;
      cnt_q       <= cnt_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_err_q   <= cfg_err_d;
      state_q     <= state_d;
    end
  end

  assign out_en = cfg_valid_q & ~config_enable;

  // Scan chain: BLE0 takes the tile scan input, each later BLE takes its predecessor
  assign sc_chain = {q_vec[N_BLE-2:0], clb_sc_in};

  genvar gi;
  generate
    for (gi = 0; gi < N_BLE; gi++) begin : g_ble
      clb_ble #(
        .K     (K),
        .I_W   (I_W),
        .N_BLE (N_BLE)
      ) u_ble (
        .clk         (clb_clk),
        .rst_n       (pReset),
        .cfg         (cfg_q[gi*CFG_PER_BLE +: CFG_PER_BLE]),
        .src         ({q_vec, clb_I}),
        .sc_in_local (sc_chain[gi]),
        .hold_en     (config_enable),
        .scan_en     (Test_en),
        .load_en     (cfg_valid_q),
        .out_en      (out_en),
        .q           (q_vec[gi]),
        .o           (clb_O[gi])
      );
    end
  endgenerate

  assign clb_sc_out = q_vec[N_BLE-1];
  assign ccff_tail  = cfg_q[CFG_BITS-1];
  assign cfg_valid  = cfg_valid_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_grid_clb_param.sv
// Self-checking bench for grid_clb_param: directed corner cases, a vector table and random segments.
module tb_grid_clb_param;

  localparam int N_BLE    = 4;
  localparam int K        = 4;
  localparam int I_W      = 10;
  localparam int SELW     = $clog2(I_W + N_BLE);
  localparam int CPB      = K * SELW + (1 << K) + 1;
  localparam int CFG_BITS = N_BLE * CPB;

  logic             clb_clk = 1'b0;
  logic             pReset;
  logic             config_enable;
  logic             Test_en;
  logic             ccff_head;
  logic [I_W-1:0]   clb_I;
  logic             clb_sc_in;
  logic [N_BLE-1:0] clb_O;
  logic             clb_sc_out;
  logic             ccff_tail;
  logic             cfg_valid;
  logic             cfg_err;

  int vec_count   = 0;
  int miscompares = 0;

  // Behavioural model state
  bit [CFG_BITS-1:0] m_cfg;
  bit [N_BLE-1:0]    m_q;
  int                m_cnt;
  bit                m_valid;
  bit                m_err;
  bit                m_loading;

  logic [CFG_BITS-1:0] img;

  typedef struct {
    logic [I_W-1:0]   in_i;
    logic [N_BLE-1:0] exp_o;
  } vec_t;
  vec_t table_v [7];

  grid_clb_param dut (
    .clb_clk       (clb_clk),
    .pReset        (pReset),
    .config_enable (config_enable),
    .Test_en       (Test_en),
    .ccff_head     (ccff_head),
    .clb_I         (clb_I),
    .clb_sc_in     (clb_sc_in),
    .clb_O         (clb_O),
    .clb_sc_out    (clb_sc_out),
    .ccff_tail     (ccff_tail),
    .cfg_valid     (cfg_valid),
    .cfg_err       (cfg_err)
  );

  always #5 clb_clk = ~clb_clk;

  // Model LUT output of BLE i from its configuration fields and current sources
  function automatic bit mlut(input int i);
    int base;
    int idx;
    int j;
    bit s;
    base = i * CPB;
    idx  = 0;
    for (int k = 0; k < K; k++) begin
      j = int'(m_cfg[base + k*SELW +: SELW]);
      if (j < I_W) s = clb_I[j];
      else if (j < I_W + N_BLE) s = m_q[j - I_W];
      else s = 1'b0;
      idx = idx + (int'(s) << k);
    end
    return m_cfg[base + K*SELW + idx];
  endfunction

  // Expected {clb_O, ccff_tail, clb_sc_out, cfg_valid, cfg_err}
  function automatic logic [N_BLE+3:0] modelBundle();
    logic [N_BLE-1:0] o;
    for (int i = 0; i < N_BLE; i++) begin
      if (m_valid && !config_enable)
        o[i] = m_cfg[i*CPB + K*SELW + 16] ? m_q[i] : mlut(i);
      else
        o[i] = 1'b0;
    end
    return {o, m_cfg[CFG_BITS-1], m_q[N_BLE-1], m_valid, m_err};
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic modelEdge();
    bit [N_BLE-1:0] lut;
    bit old_valid;
    for (int i = 0; i < N_BLE; i++) lut[i] = mlut(i);
    old_valid = m_valid;
    if (!pReset) begin
      m_cfg = '0; m_q = '0; m_cnt = 0; m_valid = 0; m_err = 0; m_loading = 0;
    end else if (config_enable) begin
      m_cfg = {m_cfg[CFG_BITS-2:0], ccff_head};
      if (m_cnt < CFG_BITS + 1) m_cnt = m_cnt + 1;
      m_valid = 0; m_err = 0; m_loading = 1;
    end else begin
      if (m_loading) begin
        m_valid = (m_cnt == CFG_BITS);
        m_err   = (m_cnt != CFG_BITS);
        m_cnt = 0; m_loading = 0;
      end
      if (Test_en) m_q = {m_q[N_BLE-2:0], clb_sc_in};
      else if (old_valid) m_q = lut;
    end
  endtask

  task automatic checkOutput(input string name);
    logic [N_BLE+3:0] exp_b, act_b;
    exp_b = modelBundle();
    act_b = {clb_O, ccff_tail, clb_sc_out, cfg_valid, cfg_err};
    vec_count++;
    if (act_b !== exp_b) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b expected %b (O,tail,sc,valid,err) at %0t", name, act_b, exp_b, $time);
    end
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    vec_count++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, compare before the edge, step the model at the edge
  task automatic applyStimulus(input logic rst_v, input logic ce_v, input logic te_v,
                               input logic head_v, input logic sc_v, input logic [I_W-1:0] i_v);
    pReset = rst_v; config_enable = ce_v; Test_en = te_v;
    ccff_head = head_v; clb_sc_in = sc_v; clb_I = i_v;
    #1;
    checkOutput("pre_edge");
    @(posedge clb_clk);
    modelEdge();
    #1;
  endtask

  task automatic setBle(input int i, input int s0, input int s1, input int s2, input int s3,
                        input logic [15:0] t, input logic md);
    int base;
    int s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    base = i * CPB;
    for (int k = 0; k < K; k++) img[base + k*SELW +: SELW] = SELW'(s[k]);
    img[base + K*SELW +: 16] = t;
    img[base + K*SELW + 16]  = md;
  endtask

  // Stream n bits, MSB of the image first; bits past the image are random
  task automatic streamBits(input int n);
    logic b;
    for (int c = 0; c < n; c++) begin
      b = (c < CFG_BITS) ? img[CFG_BITS-1-c] : 1'($urandom);
      applyStimulus(1'b1, 1'b1, 1'($urandom), b, 1'($urandom), I_W'($urandom));
    end
  endtask

  task automatic endLoad();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, I_W'($urandom));
  endtask

  initial begin
    logic [3:0] pat;
    int len;

    table_v[0] = '{10'h000, 4'h8};
    table_v[1] = '{10'h001, 4'h9};
    table_v[2] = '{10'h028, 4'hC};
    table_v[3] = '{10'h029, 4'hD};
    table_v[4] = '{10'h008, 4'h8};
    table_v[5] = '{10'h3FF, 4'hD};
    table_v[6] = '{10'h020, 4'h8};

    // Reset with random inputs
    pReset = 1'b0; config_enable = 1'($urandom); Test_en = 1'($urandom);
    ccff_head = 1'($urandom); clb_sc_in = 1'($urandom); clb_I = I_W'($urandom);
    @(posedge clb_clk);
    modelEdge();
    #1;
    config_enable = 1'b0;
    #1;
    checkVal("reset_O", int'(clb_O), 0);
    checkVal("reset_tail", int'(ccff_tail), 0);
    checkVal("reset_sc", int'(clb_sc_out), 0);
    checkVal("reset_valid", int'(cfg_valid), 0);
    checkVal("reset_err", int'(cfg_err), 0);
    @(posedge clb_clk);
    modelEdge();
    #1;

    // Image A: BLE0 buffer of clb_I[0], BLE1 registered inverter of its own q,
    // BLE2 AND of clb_I[3]&clb_I[5], BLE3 out-of-range select giving constant 1
    img = '0;
    setBle(0, 0, 0, 0, 0, 16'hAAAA, 1'b0);
    setBle(1, 11, 0, 0, 0, 16'h5555, 1'b1);
    setBle(2, 3, 5, 0, 0, 16'h8888, 1'b0);
    setBle(3, 15, 0, 0, 0, 16'h5555, 1'b0);
    streamBits(CFG_BITS);
    checkVal("valid_before_check", int'(cfg_valid), 0);
    endLoad();
    checkVal("valid_after_check", int'(cfg_valid), 1);
    checkVal("err_after_exact", int'(cfg_err), 0);
    checkVal("tail_first_bit", int'(ccff_tail), int'(img[CFG_BITS-1]));

    // Registered feedback toggles every edge starting from the reset value
    for (int c = 0; c < 4; c++) begin
      checkVal("toggle_q1", int'(clb_O[1]), c % 2);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, I_W'($urandom));
    end

    // Combinational vectors (BLE1 masked out)
    for (int r = 0; r < 7; r++) begin
      clb_I = table_v[r].in_i;
      #1;
      checkVal("table_comb", int'(clb_O & 4'b1101), int'(table_v[r].exp_o));
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, table_v[r].in_i);
    end

    // Short and long loads are rejected and keep the tile silent
    streamBits(CFG_BITS - 1);
    endLoad();
    checkVal("short_err", int'(cfg_err), 1);
    checkVal("short_valid", int'(cfg_valid), 0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b0, 1'($urandom), 1'b0, 1'($urandom), I_W'($urandom));
      checkVal("short_silent", int'(clb_O), 0);
    end
    streamBits(CFG_BITS + 1);
    endLoad();
    checkVal("long_err", int'(cfg_err), 1);
    checkVal("long_valid", int'(cfg_valid), 0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b0, 1'($urandom), 1'b0, 1'($urandom), I_W'($urandom));
      checkVal("long_silent", int'(clb_O), 0);
    end
    streamBits(CFG_BITS);
    endLoad();
    checkVal("reload_err", int'(cfg_err), 0);
    checkVal("reload_valid", int'(cfg_valid), 1);

    // Scan shift 1,0,1,1 then freeze by asserting config_enable
    pat = 4'b1101;
    for (int p = 0; p < 4; p++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, pat[p], I_W'($urandom));
    end
    checkVal("scan_out_first", int'(clb_sc_out), 1);
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'($urandom), 1'($urandom), I_W'($urandom));
      checkVal("freeze_O", int'(clb_O), 0);
      checkVal("freeze_sc", int'(clb_sc_out), 1);
    end
    endLoad();
    checkVal("scan_interrupt_err", int'(cfg_err), 1);

    // Reset in the middle of a load discards the partial bits
    for (int c = 0; c < 60; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, I_W'($urandom));
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, I_W'($urandom));
    checkVal("midload_reset_valid", int'(cfg_valid), 0);
    checkVal("midload_reset_tail", int'(ccff_tail), 0);
    for (int w = 0; w < CFG_BITS; w++) img[w] = 1'($urandom);
    for (int c = 0; c < CFG_BITS; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, img[CFG_BITS-1-c], 1'b0, I_W'($urandom));
      if (c == 99) checkVal("no_partial_tail", int'(ccff_tail), 0);
    end
    endLoad();
    checkVal("after_reset_valid", int'(cfg_valid), 1);
    checkVal("after_reset_err", int'(cfg_err), 0);

    // Random segments: random image, mostly exact length, then random operation
    for (int seg = 0; seg < 8; seg++) begin
      for (int w = 0; w < CFG_BITS; w++) img[w] = 1'($urandom);
      len = CFG_BITS + int'($urandom_range(0, 3)) - 1;
      if (len > CFG_BITS + 1) len = CFG_BITS;
      streamBits(len);
      endLoad();
      for (int c = 0; c < 40; c++) begin
        applyStimulus(($urandom_range(0, 63) != 0), 1'b0, ($urandom_range(0, 3) == 0),
                      1'($urandom), 1'($urandom), I_W'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
